sargantana_icache_refill_writer: RTL and testbench
==================================================

# sargantana_icache_refill_writer

Write-port front end for the instruction-cache way arrays. It collects refill beats returning from the L2 into one SET_WIDHT-bit set and commits that set to the selected way in a single write cycle. It also arbitrates the shared way request/address bus between fetch lookups and refill writes. Sits directly upstream of the way array instances, which consume its `way_*` outputs.

## Interface
- SET_WIDHT, 128, width of one set written to a way
- ADDR_WIDHT, 8, set index width
- BEAT_WIDHT, 32, refill beat width; SET_WIDHT must be an integer multiple
- N_WAYS, 4, number of way arrays; WAY_IDX_W = $clog2(N_WAYS)

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- refill_start_i  in  1  starts a refill; sampled only in IDLE
- refill_addr_i  in  ADDR_WIDHT  set index for the refill
- refill_way_i  in  WAY_IDX_W  victim way index
- flush_i  in  1  abort the in-progress collection
- beat_valid_i  in  1  refill beat valid
- beat_data_i  in  BEAT_WIDHT  refill beat payload
- beat_ready_o  out  1  beat accepted when valid & ready
- lookup_req_i  in  1  fetch read request
- lookup_addr_i  in  ADDR_WIDHT  fetch set index
- lookup_gnt_o  out  1  lookup driven to the ways this cycle
- way_req_o  out  N_WAYS  per-way request
- way_we_o  out  1  write enable, common to all ways
- way_addr_o  out  ADDR_WIDHT  common address
- way_data_o  out  SET_WIDHT  common write data
- busy_o  out  1  refill in progress (COLLECT or WRITE)
- done_o  out  1  one-cycle pulse after the write is issued

## Operation
- BEATS = SET_WIDHT/BEAT_WIDHT. Beat counter is $clog2(BEATS) bits and never wraps past BEATS-1.
- FSM states: IDLE, COLLECT, WRITE.
- IDLE:
  - On refill_start_i, latch addr and way, clear the counter, go to COLLECT.
  - beat_ready_o = 0; beats presented in IDLE are not consumed.
- COLLECT:
  - beat_ready_o = 1.
  - Each accepted beat k is stored at buffer[k*BEAT_WIDHT +: BEAT_WIDHT], so the first beat lands in the LSBs. Counter then increments.
  - Accepting beat BEATS-1 moves the FSM to WRITE.
  - Gaps in beat_valid_i are allowed; the FSM holds.
- WRITE (exactly one cycle):
  - way_req_o = one-hot(latched way), way_we_o = 1.
  - way_addr_o = latched addr, way_data_o = assembled buffer.
  - Next state IDLE; done_o is registered high for the following cycle.
- Lookup arbitration: refill write has absolute priority.
  - In IDLE or COLLECT, lookup_gnt_o = lookup_req_i. When granted: way_req_o = all ones, way_we_o = 0, way_addr_o = lookup_addr_i.
  - In WRITE, lookup_gnt_o = 0; the requester must retry.
  - When no access is issued: way_req_o = 0, way_we_o = 0.
- flush_i:
  - In COLLECT: return to IDLE, discard collected beats, clear the counter, no write, no done_o. If a beat is accepted in the same cycle, it is discarded.
  - In WRITE: ignored; the write completes and done_o pulses.
  - In IDLE: no effect. If asserted together with refill_start_i, flush wins and the start is dropped.
- refill_start_i outside IDLE is ignored.
- way_data_o outside WRITE is don't-care; drive the buffer.

## Timing
- Reset (async assert, sync deassert by the environment):
  - state IDLE, counter 0, latched addr/way 0, buffer 0, done_o 0.
  - Hence busy_o 0, beat_ready_o 0, way_we_o 0, way_req_o = {N_WAYS{lookup_req_i}}, lookup_gnt_o = lookup_req_i.
- Reset mid-refill aborts immediately: no write is issued and no done_o.
- beat_ready_o, lookup_gnt_o and way_* are combinational from state and lookup inputs. There is no path from beat_valid_i to beat_ready_o.
- Refill latency with back-to-back beats (BEATS = 4):
  - start sampled at cycle T; beats accepted at T+1..T+4;
  - WRITE at T+5; done_o at T+6; busy_o high T+1..T+5;
  - a new start is accepted at T+6.
- The way arrays return read data one cycle after a granted lookup; this block does not register it.

## Test plan
- Reset then lookup_req_i = 1, addr 0x3C → lookup_gnt_o = 1, way_req_o = 4'b1111, way_we_o = 0, way_addr_o = 0x3C, busy_o = 0.
- Start addr 0x12, way 2; beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 back-to-back → at T+5: way_req_o = 4'b0100, way_we_o = 1, way_addr_o = 0x12, way_data_o = 0x44444444_33333333_22222222_11111111; done_o = 1 at T+6 only.
- Same refill with beat_valid_i low for 2 cycles between beats 1 and 2 → WRITE at T+7 with identical data; beat_ready_o stays 1 throughout COLLECT.
- lookup_req_i held high during a refill → lookup_gnt_o = 1 every cycle except the WRITE cycle (0); way_we_o = 1 only in WRITE.
- flush_i after 2 beats, then a new refill to addr 0x05, way 0 → no write to 0x12; the second refill writes only its own 4 beats; exactly one done_o.
- rst_i pulsed after beat 3 → outputs return to reset values asynchronously; no way_we_o; a subsequent start plus 4 beats writes correctly.

Source files
------------

// File: rtl/sargantana_icache_refill_writer_if.sv
// Refill, flush, lookup and way-array signals of the icache refill writer.
// The slave modport is the writer; the master modport is its environment.
interface sargantana_icache_refill_writer_if #(
    parameter int unsigned SET_WIDHT  = 128,
    parameter int unsigned ADDR_WIDHT = 8,
    parameter int unsigned BEAT_WIDHT = 32,
    parameter int unsigned N_WAYS     = 4,
    parameter int unsigned WAY_IDX_W  = (N_WAYS > 1) ? $clog2(N_WAYS) : 1
);

    logic                  refill_start_i;
    logic [ADDR_WIDHT-1:0] refill_addr_i;
    logic [WAY_IDX_W-1:0]  refill_way_i;
    logic                  flush_i;
    logic                  beat_valid_i;
    logic [BEAT_WIDHT-1:0] beat_data_i;
    logic                  beat_ready_o;
    logic                  lookup_req_i;
    logic [ADDR_WIDHT-1:0] lookup_addr_i;
    logic                  lookup_gnt_o;
    logic [N_WAYS-1:0]     way_req_o;
    logic                  way_we_o;
    logic [ADDR_WIDHT-1:0] way_addr_o;
    logic [SET_WIDHT-1:0]  way_data_o;
    logic                  busy_o;
    logic                  done_o;

    modport slave (
        input  refill_start_i,
        input  refill_addr_i,
        input  refill_way_i,
        input  flush_i,
        input  beat_valid_i,
        input  beat_data_i,
        output beat_ready_o,
        input  lookup_req_i,
        input  lookup_addr_i,
        output lookup_gnt_o,
        output way_req_o,
        output way_we_o,
        output way_addr_o,
        output way_data_o,
        output busy_o,
        output done_o
    );

    modport master (
        output refill_start_i,
        output refill_addr_i,
        output refill_way_i,
        output flush_i,
        output beat_valid_i,
        output beat_data_i,
        input  beat_ready_o,
        output lookup_req_i,
        output lookup_addr_i,
        input  lookup_gnt_o,
        input  way_req_o,
        input  way_we_o,
        input  way_addr_o,
        input  way_data_o,
        input  busy_o,
        input  done_o
    );

endinterface

// File: rtl/sargantana_icache_refill_writer.sv
// Assembles L2 refill beats into one set and writes it to the victim way in a
// single cycle; fetch lookups share the way bus but yield to the refill write.
module sargantana_icache_refill_writer #(
    parameter int unsigned SET_WIDHT  = 128,
    parameter int unsigned ADDR_WIDHT = 8,
    parameter int unsigned BEAT_WIDHT = 32,
    parameter int unsigned N_WAYS     = 4,
    parameter int unsigned WAY_IDX_W  = (N_WAYS > 1) ? $clog2(N_WAYS) : 1
) (
    input logic clk_i,
    input logic rst_i,
    sargantana_icache_refill_writer_if.slave bus
);

    localparam int unsigned BEATS = SET_WIDHT / BEAT_WIDHT;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCollect = 2'd1;
    localparam logic [1:0] StWrite   = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDHT-1:0] addr_q, addr_d;
    logic [WAY_IDX_W-1:0]  way_q, way_d;
    logic [SET_WIDHT-1:0]  buffer_q, buffer_d;
    logic                  done_q, done_d;

    logic                  beat_fire;
    logic [N_WAYS-1:0]     way_onehot;

    assign beat_fire  = (state_q == StCollect) && bus.beat_valid_i;
    assign way_onehot = N_WAYS'(1) << way_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        way_d    = way_q;
        buffer_d = buffer_q;
        done_d   = 1'b0;

        case (state_q)
            StIdle: begin
                // Flush in the same cycle as start drops the start.
                if (bus.refill_start_i && !bus.flush_i) begin
                    addr_d  = bus.refill_addr_i;
                    way_d   = bus.refill_way_i;
                    cnt_d   = '0;
                    state_d = StCollect;
                end
            end
            StCollect: begin
                if (bus.flush_i) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (beat_fire) begin
                    for (int k = 0; k < int'(BEATS); k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            buffer_d[k*BEAT_WIDHT +: BEAT_WIDHT] = bus.beat_data_i;
                        end
                    end
                    if (cnt_q == CNT_W'(BEATS - 1)) begin
                        state_d = StWrite;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StWrite: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            addr_q   <= '0;
            way_q    <= '0;
            buffer_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            way_q    <= way_d;
            buffer_q <= buffer_d;
            done_q   <= done_d;
        end
    end

    // The refill write owns the way bus; lookups are granted in any other state.
    always_comb begin
        bus.lookup_gnt_o = 1'b0;
        bus.way_req_o    = '0;
        bus.way_we_o     = 1'b0;
        bus.way_addr_o   = bus.lookup_addr_i;
        if (state_q == StWrite) begin
            bus.way_req_o  = way_onehot;
            bus.way_we_o   = 1'b1;
            bus.way_addr_o = addr_q;
        end else if (bus.lookup_req_i) begin
            bus.lookup_gnt_o = 1'b1;
            bus.way_req_o    = '1;
        end
    end

    assign bus.way_data_o   = buffer_q;
    assign bus.beat_ready_o = (state_q == StCollect);
    assign bus.busy_o       = (state_q != StIdle);
    assign bus.done_o       = done_q;

endmodule

// File: tb/tb_sargantana_icache_refill_writer.sv
// Directed bench for the icache refill writer: lookup grant, refill assembly,
// beat gaps, flush and asynchronous reset, checked against hand-computed values.
module tb_sargantana_icache_refill_writer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sargantana_icache_refill_writer_if #(
        .SET_WIDHT (128),
        .ADDR_WIDHT(8),
        .BEAT_WIDHT(32),
        .N_WAYS    (4)
    ) bus ();

    sargantana_icache_refill_writer #(
        .SET_WIDHT (128),
        .ADDR_WIDHT(8),
        .BEAT_WIDHT(32),
        .N_WAYS    (4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are then sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d);
        bus.beat_valid_i = 1'b1;
        bus.beat_data_i  = d;
        tick();
        bus.beat_valid_i = 1'b0;
    endtask

    task automatic start(input logic [7:0] a, input logic [1:0] w);
        bus.refill_start_i = 1'b1;
        bus.refill_addr_i  = a;
        bus.refill_way_i   = w;
        tick();
        bus.refill_start_i = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.refill_start_i = 1'b0;
        bus.refill_addr_i  = '0;
        bus.refill_way_i   = '0;
        bus.flush_i        = 1'b0;
        bus.beat_valid_i   = 1'b0;
        bus.beat_data_i    = '0;
        bus.lookup_req_i   = 1'b0;
        bus.lookup_addr_i  = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_busy", 128'(bus.busy_o), 128'(0));
        chk("rst_ready", 128'(bus.beat_ready_o), 128'(0));
        chk("rst_we", 128'(bus.way_we_o), 128'(0));
        chk("rst_req_idle", 128'(bus.way_req_o), 128'(4'b0000));
        chk("rst_done", 128'(bus.done_o), 128'(0));
        chk("rst_data", bus.way_data_o, 128'(0));

        // Plain lookup
        bus.lookup_req_i  = 1'b1;
        bus.lookup_addr_i = 8'h3C;
        #1;
        chk("lk_gnt", 128'(bus.lookup_gnt_o), 128'(1));
        chk("lk_req", 128'(bus.way_req_o), 128'(4'b1111));
        chk("lk_we", 128'(bus.way_we_o), 128'(0));
        chk("lk_addr", 128'(bus.way_addr_o), 128'(8'h3C));
        chk("lk_busy", 128'(bus.busy_o), 128'(0));

        // Beats in IDLE are not consumed
        bus.beat_valid_i = 1'b1;
        bus.beat_data_i  = 32'hDEADBEEF;
        #1;
        chk("idle_ready", 128'(bus.beat_ready_o), 128'(0));
        tick();
        bus.beat_valid_i = 1'b0;
        chk("idle_nobusy", 128'(bus.busy_o), 128'(0));

        // Back-to-back refill, lookup held high throughout
        start(8'h12, 2'd2);
        chk("r1_busy", 128'(bus.busy_o), 128'(1));
        chk("r1_ready", 128'(bus.beat_ready_o), 128'(1));
        chk("r1_gnt_col", 128'(bus.lookup_gnt_o), 128'(1));
        chk("r1_we_col", 128'(bus.way_we_o), 128'(0));
        beat(32'h11111111);
        beat(32'h22222222);
        chk("r1_gnt_col2", 128'(bus.lookup_gnt_o), 128'(1));
        beat(32'h33333333);
        beat(32'h44444444);
        chk("r1_req", 128'(bus.way_req_o), 128'(4'b0100));
        chk("r1_we", 128'(bus.way_we_o), 128'(1));
        chk("r1_addr", 128'(bus.way_addr_o), 128'(8'h12));
        chk("r1_data", bus.way_data_o, 128'h44444444_33333333_22222222_11111111);
        chk("r1_gnt_wr", 128'(bus.lookup_gnt_o), 128'(0));
        chk("r1_busy_wr", 128'(bus.busy_o), 128'(1));
        chk("r1_done_wr", 128'(bus.done_o), 128'(0));
        tick();
        chk("r1_done", 128'(bus.done_o), 128'(1));
        chk("r1_idle", 128'(bus.busy_o), 128'(0));
        chk("r1_we_after", 128'(bus.way_we_o), 128'(0));
        chk("r1_gnt_after", 128'(bus.lookup_gnt_o), 128'(1));
        tick();
        chk("r1_done_once", 128'(bus.done_o), 128'(0));
        bus.lookup_req_i = 1'b0;

        // Gap of two cycles between beats 1 and 2; start outside IDLE ignored
        start(8'h12, 2'd2);
        beat(32'h11111111);
        beat(32'h22222222);
        bus.refill_start_i = 1'b1;
        bus.refill_addr_i  = 8'h77;
        bus.refill_way_i   = 2'd1;
        tick();
        chk("gap_ready1", 128'(bus.beat_ready_o), 128'(1));
        chk("gap_we1", 128'(bus.way_we_o), 128'(0));
        tick();
        bus.refill_start_i = 1'b0;
        chk("gap_ready2", 128'(bus.beat_ready_o), 128'(1));
        chk("gap_req_none", 128'(bus.way_req_o), 128'(4'b0000));
        beat(32'h33333333);
        chk("gap_we3", 128'(bus.way_we_o), 128'(0));
        beat(32'h44444444);
        chk("gap_we", 128'(bus.way_we_o), 128'(1));
        chk("gap_req", 128'(bus.way_req_o), 128'(4'b0100));
        chk("gap_addr", 128'(bus.way_addr_o), 128'(8'h12));
        chk("gap_data", bus.way_data_o, 128'h44444444_33333333_22222222_11111111);
        tick();
        chk("gap_done", 128'(bus.done_o), 128'(1));
        tick();

        // Flush after 2 beats, beat presented with flush is discarded
        start(8'h12, 2'd2);
        beat(32'h11111111);
        beat(32'h22222222);
        bus.flush_i      = 1'b1;
        bus.beat_valid_i = 1'b1;
        bus.beat_data_i  = 32'h99999999;
        tick();
        bus.flush_i      = 1'b0;
        bus.beat_valid_i = 1'b0;
        chk("fl_idle", 128'(bus.busy_o), 128'(0));
        chk("fl_we", 128'(bus.way_we_o), 128'(0));
        chk("fl_done", 128'(bus.done_o), 128'(0));
        tick();
        chk("fl_done2", 128'(bus.done_o), 128'(0));
        start(8'h05, 2'd0);
        beat(32'hA0A0A0A0);
        beat(32'hB1B1B1B1);
        beat(32'hC2C2C2C2);
        chk("fl2_we_pre", 128'(bus.way_we_o), 128'(0));
        beat(32'hD3D3D3D3);
        chk("fl2_we", 128'(bus.way_we_o), 128'(1));
        chk("fl2_req", 128'(bus.way_req_o), 128'(4'b0001));
        chk("fl2_addr", 128'(bus.way_addr_o), 128'(8'h05));
        chk("fl2_data", bus.way_data_o, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0);
        tick();
        chk("fl2_done", 128'(bus.done_o), 128'(1));
        tick();
        chk("fl2_done_once", 128'(bus.done_o), 128'(0));

        // Flush together with start in IDLE drops the start
        bus.flush_i = 1'b1;
        start(8'h40, 2'd3);
        bus.flush_i = 1'b0;
        chk("flst_busy", 128'(bus.busy_o), 128'(0));

        // Asynchronous reset after beat 3
        start(8'h12, 2'd2);
        beat(32'h11111111);
        beat(32'h22222222);
        beat(32'h33333333);
        rst = 1'b1;
        #1;
        chk("ar_busy", 128'(bus.busy_o), 128'(0));
        chk("ar_ready", 128'(bus.beat_ready_o), 128'(0));
        chk("ar_we", 128'(bus.way_we_o), 128'(0));
        chk("ar_data", bus.way_data_o, 128'(0));
        #2;
        rst = 1'b0;
        bus.beat_valid_i = 1'b1;
        bus.beat_data_i  = 32'h44444444;
        tick();
        bus.beat_valid_i = 1'b0;
        chk("ar_we_after", 128'(bus.way_we_o), 128'(0));
        tick();
        chk("ar_done_after", 128'(bus.done_o), 128'(0));
        start(8'hE7, 2'd3);
        beat(32'h01234567);
        beat(32'h89ABCDEF);
        beat(32'hFEDCBA98);
        beat(32'h76543210);
        chk("ar2_we", 128'(bus.way_we_o), 128'(1));
        chk("ar2_req", 128'(bus.way_req_o), 128'(4'b1000));
        chk("ar2_addr", 128'(bus.way_addr_o), 128'(8'hE7));
        chk("ar2_data", bus.way_data_o, 128'h76543210_FEDCBA98_89ABCDEF_01234567);
        tick();
        chk("ar2_done", 128'(bus.done_o), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
